// File: rtl/data_mem_unit_pkg.sv
// Shared load/store definitions: op encodings, op width, store-bit position,
// FSM state type and small decode helpers used by the LSQ and the data memory.
package data_mem_unit_pkg;

  localparam int LSQ_OP_WIDTH = 4;
  localparam int OP_STORE_BIT = 3;

  localparam logic [LSQ_OP_WIDTH-1:0] OP_NONE = 4'b0000;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LB   = 4'b0001;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LH   = 4'b0010;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LW   = 4'b0011;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LBU  = 4'b0100;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LHU  = 4'b0101;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_SB   = 4'b1001;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_SH   = 4'b1010;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_SW   = 4'b1011;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // Only the eight defined codes start a transaction; anything else is a no-op.
  function automatic logic op_is_valid(input logic [LSQ_OP_WIDTH-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic op_misaligned(input logic [LSQ_OP_WIDTH-1:0] op,
                                         input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return |lo;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// LSQ <-> data memory bus. The LSQ presents Op_in (nonzero = request) for a
// cycle; the memory answers with a one-cycle mem_rd_ready or mem_wr_ready
// pulse. There is no backpressure: requests seen while busy are dropped and
// flagged with req_drop, so the LSQ must issue one op per completion.
interface data_mem_unit_if;
  import data_mem_unit_pkg::*;

  logic                    rollback;
  logic [LSQ_OP_WIDTH-1:0] Op_in;
  logic [31:0]             Addr_in;
  logic [31:0]             wr_data;
  logic                    mem_rd_ready;
  logic [31:0]             mem_rd_data;
  logic                    mem_wr_ready;
  logic                    busy;
  logic                    misalign;
  logic                    req_drop;

  modport master (
    output rollback, Op_in, Addr_in, wr_data,
    input  mem_rd_ready, mem_rd_data, mem_wr_ready, busy, misalign, req_drop
  );

  modport slave (
    input  rollback, Op_in, Addr_in, wr_data,
    output mem_rd_ready, mem_rd_data, mem_wr_ready, busy, misalign, req_drop
  );
endinterface

// File: rtl/data_mem_ram.sv
// Single-port word array with per-byte write enables, synchronous write and
// combinational read. Contents are never cleared.
module data_mem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Byte-lane writes; lanes without an enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_unit.sv
// Data memory unit: accepts one load/store at a time from the LSQ, waits a
// fixed latency, then completes it against the byte-lane RAM. Loads can be
// flushed by rollback; stores are already committed and always complete.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_unit_if.slave   bus,
  output state_t           dbg_state
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [LSQ_OP_WIDTH-1:0] op_q, op_d;
  logic [AW+1:0]           addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rd_ready_q, rd_ready_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    misalign_q, misalign_d;
  logic                    drop_q, drop_d;
  logic [31:0]             rd_data_q, rd_data_d;

  logic                    req_valid, busy_w, complete;
  logic [LSQ_OP_WIDTH-1:0] cur_op;
  logic [AW+1:0]           cur_addr;
  logic [31:0]             cur_wdata, lane_wdata, ram_rdata, shifted, load_data;
  logic [3:0]              lane_be, ram_we;
  logic                    cur_mis;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^bus.Addr_in[31:AW+2];

  // The ready cycle still counts as busy, so a request arriving then is dropped.
  assign req_valid = op_is_valid(bus.Op_in);
  assign busy_w    = (state_q == ST_WAIT) | rd_ready_q | wr_ready_q;

  // With LATENCY=1 the op completes on its accept edge, straight from the inputs.
  assign cur_op    = (state_q == ST_IDLE) ? bus.Op_in : op_q;
  assign cur_addr  = (state_q == ST_IDLE) ? bus.Addr_in[AW+1:0] : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? bus.wr_data : wdata_q;
  assign cur_mis   = op_misaligned(cur_op, cur_addr[1:0]);

  // Store lane steering: replicate the low data onto every lane, enable the target ones.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = cur_wdata;
    case (cur_op)
      OP_SB: begin
        lane_be    = 4'b0001 << cur_addr[1:0];
        lane_wdata = {4{cur_wdata[7:0]}};
      end
      OP_SH: begin
        lane_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cur_wdata[15:0]}};
      end
      OP_SW:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign/zero-extend.
  assign shifted = ram_rdata >> {cur_addr[1:0], 3'b000};
  always_comb begin
    load_data = 32'h0;
    case (cur_op)
      OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_data = {24'h0, shifted[7:0]};
      OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_data = {16'h0, shifted[15:0]};
      OP_LW:   load_data = ram_rdata;
      default: load_data = 32'h0;
    endcase
  end

  // Misaligned stores and reset edges must never touch the array.
  assign ram_we = (complete && cur_op[OP_STORE_BIT] && !cur_mis && !rst) ? lane_be : 4'b0000;

  data_mem_ram #(.DEPTH(MEM_DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr[AW+1:2]),
    .wdata (lane_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, latch capture, abort handling and completion pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    complete   = 1'b0;
    rd_ready_d = 1'b0;
    wr_ready_d = 1'b0;
    misalign_d = 1'b0;
    rd_data_d  = 32'h0;
    drop_d     = req_valid & busy_w;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !busy_w && !bus.rollback) begin
          op_d    = bus.Op_in;
          addr_d  = bus.Addr_in[AW+1:0];
          wdata_d = bus.wr_data;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) complete = 1'b1;
          else              state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.rollback && !op_q[OP_STORE_BIT]) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      misalign_d = cur_mis;
      if (cur_op[OP_STORE_BIT]) begin
        wr_ready_d = 1'b1;
      end else begin
        rd_ready_d = 1'b1;
        rd_data_d  = cur_mis ? 32'h0 : load_data;
      end
    end
  end

  // State and output registers; reset beats rollback and any new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      misalign_q <= 1'b0;
      drop_q     <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      misalign_q <= misalign_d;
      drop_q     <= drop_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.mem_rd_ready = rd_ready_q;
  assign bus.mem_rd_data  = rd_data_q;
  assign bus.mem_wr_ready = wr_ready_q;
  assign bus.busy         = busy_w;
  assign bus.misalign     = misalign_q;
  assign bus.req_drop     = drop_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed corner cases plus randomized load/store
// traffic against a word-array reference model.
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam int MEM_DEPTH = 1024;
  localparam int LATENCY   = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  always #5 clk = ~clk;

  data_mem_unit_if bus ();

  data_mem_unit #(.MEM_DEPTH(MEM_DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] model_mem [MEM_DEPTH];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [3:0] op, input logic [31:0] addr);
    return (addr % ref_size(op)) != 0;
  endfunction

  function automatic int ref_index(input logic [31:0] addr);
    return int'((addr / 4) % MEM_DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] w, v;
    if (ref_misaligned(op, addr)) return 32'h0;
    w = model_mem[ref_index(addr)];
    v = w >> (8 * (addr % 4));
    case (op)
      OP_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      OP_LBU: v = v % 256;
      OP_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      OP_LHU: v = v % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] mask, w;
    int sz, off;
    if (ref_misaligned(op, addr)) return;
    sz   = ref_size(op);
    off  = int'(addr % 4);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 1) << (8 * off));
    w    = model_mem[ref_index(addr)];
    model_mem[ref_index(addr)] = (w & ~mask) | ((data << (8 * off)) & mask);
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.rollback = 1'b0;
    bus.Op_in    = OP_NONE;
    bus.Addr_in  = 32'h0;
    bus.wr_data  = 32'h0;
  endtask

  // Issue one op (called at a negedge) and follow it to completion.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input string tag,
                       output logic [31:0] got);
    bit st, mis;
    logic [31:0] exp;
    st  = op[3];
    mis = ref_misaligned(op, addr);
    if (st) begin
      exp_q.push_back(32'h0);
      ref_store(op, addr, data);
    end else begin
      exp_q.push_back(ref_load(op, addr));
    end
    got         = 32'h0;
    bus.Op_in   = op;
    bus.Addr_in = addr;
    bus.wr_data = data;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      if (k == 1) bus.Op_in = OP_NONE;
      check({tag, "/busy"}, bus.busy, 1'b1);
      if (k < LATENCY) begin
        check({tag, "/early_ready"}, {bus.mem_rd_ready, bus.mem_wr_ready}, 2'b00);
      end else begin
        exp = exp_q.pop_front();
        got = bus.mem_rd_data;
        check({tag, "/rd_ready"}, bus.mem_rd_ready, !st);
        check({tag, "/wr_ready"}, bus.mem_wr_ready, st);
        check({tag, "/misalign"}, bus.misalign, mis);
        check({tag, "/rd_data"}, bus.mem_rd_data, exp);
      end
    end
    @(negedge clk);
    check({tag, "/busy_after"}, bus.busy, 1'b0);
    check({tag, "/idle_outputs"}, {bus.mem_rd_ready, bus.mem_wr_ready, bus.mem_rd_data}, 34'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] got;
  logic [3:0]  op_tab [8];

  initial begin
    op_tab = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst/rd_ready", bus.mem_rd_ready, 1'b0);
    check("rst/rd_data",  bus.mem_rd_data,  32'h0);
    check("rst/wr_ready", bus.mem_wr_ready, 1'b0);
    check("rst/busy",     bus.busy,         1'b0);
    check("rst/misalign", bus.misalign,     1'b0);
    check("rst/req_drop", bus.req_drop,     1'b0);
    check("rst/state",    dbg_state,        ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Basic store then load
    do_op(OP_SW, 32'h10, 32'hDEAD_BEEF, "sw10", got);
    do_op(OP_LW, 32'h10, 32'h0, "lw10", got);
    check("lw10/const", got, 32'hDEAD_BEEF);

    // Extension cases
    do_op(OP_SW, 32'h20, 32'h80FF_7F01, "sw20", got);
    do_op(OP_LB, 32'h21, 32'h0, "lb21", got);   check("lb21/const", got, 32'h0000_007F);
    do_op(OP_LB, 32'h22, 32'h0, "lb22", got);   check("lb22/const", got, 32'hFFFF_FFFF);
    do_op(OP_LBU, 32'h23, 32'h0, "lbu23", got); check("lbu23/const", got, 32'h0000_0080);
    do_op(OP_LH, 32'h22, 32'h0, "lh22", got);   check("lh22/const", got, 32'hFFFF_80FF);
    do_op(OP_LHU, 32'h22, 32'h0, "lhu22", got); check("lhu22/const", got, 32'h0000_80FF);

    // Byte store preserves other lanes
    do_op(OP_SW, 32'h30, 32'h1122_3344, "sw30", got);
    do_op(OP_SB, 32'h31, 32'h0000_00AA, "sb31", got);
    do_op(OP_LW, 32'h30, 32'h0, "lw30", got);   check("lw30/const", got, 32'h1122_AA44);

    // Misaligned accesses
    do_op(OP_SW, 32'h40, 32'h5566_7788, "sw40", got);
    do_op(OP_LW, 32'h42, 32'h0, "lw42_mis", got);
    do_op(OP_SH, 32'h43, 32'h0000_BEEF, "sh43_mis", got);
    do_op(OP_LW, 32'h40, 32'h0, "lw40", got);   check("lw40/const", got, 32'h5566_7788);

    // Upper address bits alias onto the same word
    do_op(OP_LW, 32'h10 + 4 * MEM_DEPTH, 32'h0, "alias1", got);
    check("alias1/const", got, 32'hDEAD_BEEF);
    do_op(OP_LW, 32'h8000_0010, 32'h0, "alias2", got);
    check("alias2/const", got, 32'hDEAD_BEEF);

    // Rollback aborts an in-flight load
    bus.Op_in = OP_LW; bus.Addr_in = 32'h10;
    @(negedge clk);
    check("rb_ld/busy1", bus.busy, 1'b1);
    bus.Op_in = OP_NONE; bus.rollback = 1'b1;
    @(negedge clk);
    bus.rollback = 1'b0;
    check("rb_ld/busy2", bus.busy, 1'b0);
    check("rb_ld/rd_ready", bus.mem_rd_ready, 1'b0);
    check("rb_ld/state", dbg_state, ST_IDLE);
    @(negedge clk);
    check("rb_ld/rd_ready_late", bus.mem_rd_ready, 1'b0);

    // Rollback does not abort an in-flight store
    bus.Op_in = OP_SW; bus.Addr_in = 32'h60; bus.wr_data = 32'hA5A5_0F0F;
    ref_store(OP_SW, 32'h60, 32'hA5A5_0F0F);
    @(negedge clk);
    bus.Op_in = OP_NONE; bus.rollback = 1'b1;
    check("rb_st/busy1", bus.busy, 1'b1);
    @(negedge clk);
    bus.rollback = 1'b0;
    check("rb_st/wr_ready", bus.mem_wr_ready, 1'b1);
    @(negedge clk);
    check("rb_st/busy_after", bus.busy, 1'b0);
    do_op(OP_LW, 32'h60, 32'h0, "rb_st_lw", got);
    check("rb_st_lw/const", got, 32'hA5A5_0F0F);

    // Request together with rollback in IDLE is discarded
    bus.Op_in = OP_SW; bus.Addr_in = 32'h60; bus.wr_data = 32'h1234_5678; bus.rollback = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("rb_req/busy", bus.busy, 1'b0);
    @(negedge clk);
    check("rb_req/wr_ready", bus.mem_wr_ready, 1'b0);
    do_op(OP_LW, 32'h60, 32'h0, "rb_req_lw", got);
    check("rb_req_lw/const", got, 32'hA5A5_0F0F);

    // Request while busy and in the ready cycle: dropped, first op unaffected
    bus.Op_in = OP_LW; bus.Addr_in = 32'h10;
    @(negedge clk);
    bus.Op_in = OP_SW; bus.Addr_in = 32'h10; bus.wr_data = 32'h0BAD_0BAD;
    @(negedge clk);
    check("drop/rd_ready", bus.mem_rd_ready, 1'b1);
    check("drop/rd_data", bus.mem_rd_data, 32'hDEAD_BEEF);
    check("drop/req_drop", bus.req_drop, 1'b1);
    @(negedge clk);
    bus.Op_in = OP_NONE;
    check("drop_rdy/req_drop", bus.req_drop, 1'b1);
    check("drop_rdy/busy", bus.busy, 1'b0);
    check("drop_rdy/wr_ready", bus.mem_wr_ready, 1'b0);
    @(negedge clk);
    check("drop_rdy/req_drop_clr", bus.req_drop, 1'b0);
    check("drop_rdy/wr_ready_late", bus.mem_wr_ready, 1'b0);
    do_op(OP_LW, 32'h10, 32'h0, "drop_lw", got);
    check("drop_lw/const", got, 32'hDEAD_BEEF);

    // Reset mid-op: no response, store never lands
    bus.Op_in = OP_SW; bus.Addr_in = 32'h20; bus.wr_data = 32'hCAFE_F00D;
    @(negedge clk);
    bus.Op_in = OP_NONE; rst = 1'b1;
    @(negedge clk);
    check("rst_mid/outputs", {bus.mem_rd_ready, bus.mem_wr_ready, bus.busy,
                              bus.misalign, bus.req_drop}, 5'b0);
    check("rst_mid/rd_data", bus.mem_rd_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    do_op(OP_LW, 32'h20, 32'h0, "rst_mid_lw", got);
    check("rst_mid_lw/const", got, 32'h80FF_7F01);

    // Undefined nonzero op is a no-op
    bus.Op_in = 4'b0110; bus.Addr_in = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.Op_in = OP_NONE;
      check("noop/activity", {bus.busy, bus.mem_rd_ready, bus.mem_wr_ready, bus.req_drop}, 4'b0);
    end

    // Random traffic over a preloaded region with aliased upper bits
    for (int i = 0; i < 16; i++) begin
      do_op(OP_SW, 32'h100 + 4 * i, $urandom, "rnd_init", got);
    end
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = 32'h100 + $urandom_range(0, 63) + ($urandom_range(0, 15) << 12);
      do_op(op_tab[$urandom_range(0, 7)], a, $urandom, "rnd", got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
